// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use hazard, flush, stall hold and perf counters
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [6:0]       id_opcode,
    input  logic [2:0]       id_func3,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic [4:0]       id_rd_addr,
    input  logic             id_ex_alu_src,
    input  logic             id_mem_write,
    input  logic             id_wb_reg_file,
    input  logic             id_memtoreg,
    input  logic             id_Branch_1,
    input  logic             id_jal,
    input  logic             id_jalr,
    input  logic [2:0]       id_mem_load_type,
    input  logic [1:0]       id_mem_store_type,
    input  logic [3:0]       id_alu_ctrl,
    input  logic             ex_redirect,
    input  logic             mem_stall,
    output logic             ex_valid,
    output logic [2:0]       ex_func3,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1_addr,
    output logic [4:0]       ex_rs2_addr,
    output logic [4:0]       ex_rd_addr,
    output logic             ex_ex_alu_src,
    output logic             ex_mem_write,
    output logic             ex_wb_reg_file,
    output logic             ex_memtoreg,
    output logic             ex_Branch_1,
    output logic             ex_jal,
    output logic             ex_jalr,
    output logic [2:0]       ex_mem_load_type,
    output logic [1:0]       ex_mem_store_type,
    output logic [3:0]       ex_alu_ctrl,
    output logic             stall_if_id,
    output logic [CNT_W-1:0] bubble_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef struct packed {
        logic            valid;
        logic [2:0]      func3;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1_addr;
        logic [4:0]      rs2_addr;
        logic [4:0]      rd_addr;
        logic            alu_src;
        logic            mem_write;
        logic            wb_reg_file;
        logic            memtoreg;
        logic            branch;
        logic            jal;
        logic            jalr;
        logic [2:0]      load_type;
        logic [1:0]      store_type;
        logic [3:0]      alu_ctrl;
    } ex_bundle_t;

    ex_bundle_t ex_q;
    ex_bundle_t bubble;
    ex_bundle_t capture;
    logic       rs1_used;
    logic       rs2_used;
    logic       hazard;

    always_comb begin
        bubble            = '0;
        bubble.load_type  = 3'b010;
        bubble.store_type = 2'b10;
    end

    always_comb begin
        capture.valid       = id_valid;
        capture.func3       = id_func3;
        capture.pc          = id_pc;
        capture.rs1_data    = id_rs1_data;
        capture.rs2_data    = id_rs2_data;
        capture.imm         = id_imm;
        capture.rs1_addr    = id_rs1_addr;
        capture.rs2_addr    = id_rs2_addr;
        capture.rd_addr     = id_rd_addr;
        capture.alu_src     = id_ex_alu_src;
        capture.mem_write   = id_mem_write;
        capture.wb_reg_file = id_wb_reg_file;
        capture.memtoreg    = id_memtoreg;
        capture.branch      = id_Branch_1;
        capture.jal         = id_jal;
        capture.jalr        = id_jalr;
        capture.load_type   = id_mem_load_type;
        capture.store_type  = id_mem_store_type;
        capture.alu_ctrl    = id_alu_ctrl;
    end

    // Field indices are only meaningful for opcodes that actually read them.
    always_comb begin
        rs1_used = (id_opcode != OP_LUI) && (id_opcode != OP_AUIPC) && (id_opcode != OP_JAL);
        rs2_used = (id_opcode == OP_RTYPE) || (id_opcode == OP_STORE) || (id_opcode == OP_BRANCH);
        hazard   = id_valid && ex_q.valid && ex_q.memtoreg && (ex_q.rd_addr != 5'd0) &&
                   ((rs1_used && (id_rs1_addr == ex_q.rd_addr)) ||
                    (rs2_used && (id_rs2_addr == ex_q.rd_addr)));
    end

    assign stall_if_id = mem_stall | (hazard & ~ex_redirect);

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q         <= bubble;
            bubble_count <= '0;
            flush_count  <= '0;
        end else if (mem_stall) begin
            ex_q <= ex_q;
        end else if (ex_redirect) begin
            ex_q <= bubble;
            if (id_valid && (flush_count != {CNT_W{1'b1}}))
                flush_count <= flush_count + CNT_W'(1);
        end else if (hazard) begin
            ex_q <= bubble;
            if (bubble_count != {CNT_W{1'b1}})
                bubble_count <= bubble_count + CNT_W'(1);
        end else if (id_valid) begin
            ex_q <= capture;
        end else begin
            ex_q <= bubble;
        end
    end

    assign ex_valid          = ex_q.valid;
    assign ex_func3          = ex_q.func3;
    assign ex_pc             = ex_q.pc;
    assign ex_rs1_data       = ex_q.rs1_data;
    assign ex_rs2_data       = ex_q.rs2_data;
    assign ex_imm            = ex_q.imm;
    assign ex_rs1_addr       = ex_q.rs1_addr;
    assign ex_rs2_addr       = ex_q.rs2_addr;
    assign ex_rd_addr        = ex_q.rd_addr;
    assign ex_ex_alu_src     = ex_q.alu_src;
    assign ex_mem_write      = ex_q.mem_write;
    assign ex_wb_reg_file    = ex_q.wb_reg_file;
    assign ex_memtoreg       = ex_q.memtoreg;
    assign ex_Branch_1       = ex_q.branch;
    assign ex_jal            = ex_q.jal;
    assign ex_jalr           = ex_q.jalr;
    assign ex_mem_load_type  = ex_q.load_type;
    assign ex_mem_store_type = ex_q.store_type;
    assign ex_alu_ctrl       = ex_q.alu_ctrl;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage (2-bit counters for saturation)
module tb_id_ex_stage;

    localparam int XLEN = 32;
    localparam int CW   = 2;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_ADDI  = 7'b0010011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    logic            clk = 1'b0;
    logic            rst;
    logic            id_valid;
    logic [6:0]      id_opcode;
    logic [2:0]      id_func3;
    logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]      id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic            id_ex_alu_src, id_mem_write, id_wb_reg_file, id_memtoreg;
    logic            id_Branch_1, id_jal, id_jalr;
    logic [2:0]      id_mem_load_type;
    logic [1:0]      id_mem_store_type;
    logic [3:0]      id_alu_ctrl;
    logic            ex_redirect, mem_stall;
    logic            ex_valid;
    logic [2:0]      ex_func3;
    logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]      ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
    logic            ex_ex_alu_src, ex_mem_write, ex_wb_reg_file, ex_memtoreg;
    logic            ex_Branch_1, ex_jal, ex_jalr;
    logic [2:0]      ex_mem_load_type;
    logic [1:0]      ex_mem_store_type;
    logic [3:0]      ex_alu_ctrl;
    logic            stall_if_id;
    logic [CW-1:0]   bubble_count, flush_count;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_func3(id_func3),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_ex_alu_src(id_ex_alu_src), .id_mem_write(id_mem_write), .id_wb_reg_file(id_wb_reg_file),
        .id_memtoreg(id_memtoreg), .id_Branch_1(id_Branch_1), .id_jal(id_jal), .id_jalr(id_jalr),
        .id_mem_load_type(id_mem_load_type), .id_mem_store_type(id_mem_store_type),
        .id_alu_ctrl(id_alu_ctrl), .ex_redirect(ex_redirect), .mem_stall(mem_stall),
        .ex_valid(ex_valid), .ex_func3(ex_func3), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1_addr(ex_rs1_addr),
        .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr), .ex_ex_alu_src(ex_ex_alu_src),
        .ex_mem_write(ex_mem_write), .ex_wb_reg_file(ex_wb_reg_file), .ex_memtoreg(ex_memtoreg),
        .ex_Branch_1(ex_Branch_1), .ex_jal(ex_jal), .ex_jalr(ex_jalr),
        .ex_mem_load_type(ex_mem_load_type), .ex_mem_store_type(ex_mem_store_type),
        .ex_alu_ctrl(ex_alu_ctrl), .stall_if_id(stall_if_id), .bubble_count(bubble_count),
        .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] w0;
        logic [63:0] w1;
        logic [63:0] w2;
    } exp_t;

    exp_t sb[$];
    exp_t last;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t bubble_exp();
        exp_t e;
        e.w0 = {15'd0, 1'b0, 5'd0, 4'd0, 3'b010, 2'b10, 1'b0, 1'b0, 32'd0};
        e.w1 = 64'd0;
        e.w2 = 64'd0;
        return e;
    endfunction

    // A valid, event-free decode slot is expected to appear verbatim in EX.
    function automatic exp_t cap_exp();
        exp_t e;
        if (!id_valid) return bubble_exp();
        e.w0 = {15'd0, 1'b1, id_rd_addr, id_alu_ctrl, id_mem_load_type, id_mem_store_type,
                id_memtoreg, id_wb_reg_file, id_pc};
        e.w1 = {id_rs1_data, id_imm};
        e.w2 = {14'd0, id_rs1_addr, id_rs2_addr, id_func3, id_ex_alu_src, id_mem_write,
                id_Branch_1, id_jal, id_jalr, id_rs2_data};
        return e;
    endfunction

    task automatic cycle(input exp_t e);
        exp_t x;
        sb.push_back(e);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check("ex_ctrl", {15'd0, ex_valid, ex_rd_addr, ex_alu_ctrl, ex_mem_load_type,
                          ex_mem_store_type, ex_memtoreg, ex_wb_reg_file, ex_pc}, x.w0);
        check("ex_data", {ex_rs1_data, ex_imm}, x.w1);
        check("ex_misc", {14'd0, ex_rs1_addr, ex_rs2_addr, ex_func3, ex_ex_alu_src, ex_mem_write,
                          ex_Branch_1, ex_jal, ex_jalr, ex_rs2_data}, x.w2);
    endtask

    task automatic set_id(input logic v, input logic [6:0] op, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic m2r,
                          input logic [3:0] alu, input logic [2:0] lt, input logic [31:0] pc);
        id_valid          = v;
        id_opcode         = op;
        id_rd_addr        = rd;
        id_rs1_addr       = rs1;
        id_rs2_addr       = rs2;
        id_memtoreg       = m2r;
        id_wb_reg_file    = (rd != 5'd0);
        id_alu_ctrl       = alu;
        id_mem_load_type  = lt;
        id_mem_store_type = (op == OP_STORE) ? 2'b10 : 2'b01;
        id_pc             = pc;
        id_func3          = rd[2:0];
        id_ex_alu_src     = rd[0];
        id_mem_write      = (op == OP_STORE);
        id_Branch_1       = rd[2];
        id_jal            = rd[3];
        id_jalr           = rd[4];
        id_rs1_data       = ~pc;
        id_rs2_data       = pc + 32'd4;
        id_imm            = pc << 2;
    endtask

    task automatic check_counts(input string tag, input int b, input int f);
        check({tag, "_bubble"}, 64'(bubble_count), 64'(b));
        check({tag, "_flush"}, 64'(flush_count), 64'(f));
    endtask

    initial begin
        rst = 1'b1;
        mem_stall = 1'b0;
        ex_redirect = 1'b0;
        set_id(1'b1, OP_R, 5'd3, 5'd1, 5'd2, 1'b0, 4'd0, 3'b000, 32'h80);

        // Reset wins over a valid decode instruction; stall follows mem_stall only.
        cycle(bubble_exp());
        check_counts("reset", 0, 0);
        check("reset_stall0", 64'(stall_if_id), 64'd0);
        mem_stall = 1'b1;
        #1;
        check("reset_stall1", 64'(stall_if_id), 64'd1);
        mem_stall = 1'b0;
        rst = 1'b0;

        // Back-to-back ALU: ADD x3
        set_id(1'b1, OP_R, 5'd3, 5'd1, 5'd2, 1'b0, 4'b0000, 3'b000, 32'h100);
        #1 check("add_stall", 64'(stall_if_id), 64'd0);
        cycle(cap_exp());
        check("add_stall_after", 64'(stall_if_id), 64'd0);

        // Load-use: LW x5 then ADD x6,x5,x1
        set_id(1'b1, OP_LOAD, 5'd5, 5'd2, 5'd0, 1'b1, 4'b0000, 3'b010, 32'h104);
        cycle(cap_exp());
        set_id(1'b1, OP_R, 5'd6, 5'd5, 5'd1, 1'b0, 4'b0001, 3'b000, 32'h108);
        #1 check("lu_stall", 64'(stall_if_id), 64'd1);
        cycle(bubble_exp());
        check_counts("lu", 1, 0);
        check("lu_stall_released", 64'(stall_if_id), 64'd0);
        cycle(cap_exp());
        check_counts("lu_after", 1, 0);

        // LW x0 never creates a hazard
        set_id(1'b1, OP_LOAD, 5'd0, 5'd2, 5'd0, 1'b1, 4'b0000, 3'b010, 32'h10c);
        cycle(cap_exp());
        set_id(1'b1, OP_R, 5'd1, 5'd0, 5'd0, 1'b0, 4'b0000, 3'b000, 32'h110);
        #1 check("x0_stall", 64'(stall_if_id), 64'd0);
        cycle(cap_exp());

        // LW x5 in EX against consumers that do / do not read x5
        set_id(1'b1, OP_LOAD, 5'd5, 5'd2, 5'd0, 1'b1, 4'b0000, 3'b100, 32'h114);
        cycle(cap_exp());
        set_id(1'b1, OP_LUI, 5'd5, 5'd5, 5'd5, 1'b0, 4'b0000, 3'b000, 32'h118);
        #1 check("lui_stall", 64'(stall_if_id), 64'd0);
        set_id(1'b1, OP_ADDI, 5'd7, 5'd2, 5'd5, 1'b0, 4'b0000, 3'b000, 32'h118);
        #1 check("addi_rs2_stall", 64'(stall_if_id), 64'd0);
        set_id(1'b1, OP_STORE, 5'd0, 5'd2, 5'd5, 1'b0, 4'b0000, 3'b000, 32'h118);
        #1 check("store_rs2_stall", 64'(stall_if_id), 64'd1);
        set_id(1'b0, OP_R, 5'd6, 5'd5, 5'd1, 1'b0, 4'b0000, 3'b000, 32'h118);
        #1 check("invalid_id_stall", 64'(stall_if_id), 64'd0);

        // Redirect with simultaneous hazard
        set_id(1'b1, OP_R, 5'd6, 5'd5, 5'd1, 1'b0, 4'b0000, 3'b000, 32'h118);
        ex_redirect = 1'b1;
        #1 check("redir_stall", 64'(stall_if_id), 64'd0);
        cycle(bubble_exp());
        check_counts("redir", 1, 1);

        // Redirect of an empty slot is not counted; idle slot captures as bubble
        set_id(1'b0, OP_R, 5'd8, 5'd1, 5'd2, 1'b0, 4'b0010, 3'b000, 32'h11c);
        cycle(bubble_exp());
        check_counts("redir_idle", 1, 1);
        ex_redirect = 1'b0;
        cycle(bubble_exp());
        check_counts("idle", 1, 1);

        // mem_stall for three cycles, redirect pulsed in the second
        set_id(1'b1, OP_R, 5'd9, 5'd1, 5'd2, 1'b0, 4'b0011, 3'b000, 32'h120);
        last = cap_exp();
        cycle(last);
        set_id(1'b1, OP_R, 5'd10, 5'd9, 5'd2, 1'b0, 4'b0100, 3'b000, 32'h124);
        mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ex_redirect = (i == 1);
            #1 check("ms_stall", 64'(stall_if_id), 64'd1);
            cycle(last);
            check_counts("ms", 1, 1);
        end
        ex_redirect = 1'b0;

        // Reset asserted mid-stall overrides the hold
        rst = 1'b1;
        #1 check("rst_ms_stall", 64'(stall_if_id), 64'd1);
        cycle(bubble_exp());
        check_counts("rst_mid", 0, 0);
        rst = 1'b0;
        mem_stall = 1'b0;

        // Saturation of the 2-bit bubble counter
        for (int i = 0; i < 5; i++) begin
            set_id(1'b1, OP_LOAD, 5'd5, 5'd2, 5'd0, 1'b1, 4'b0000, 3'b010, 32'h200 + 32'(i * 8));
            cycle(cap_exp());
            set_id(1'b1, OP_R, 5'd6, 5'd5, 5'd1, 1'b0, 4'b0000, 3'b000, 32'h204 + 32'(i * 8));
            cycle(bubble_exp());
            if (i == 2) check_counts("sat_mid", 3, 0);
        end
        check_counts("sat_bubble", 3, 0);

        // Saturation of the flush counter
        ex_redirect = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_id(1'b1, OP_R, 5'd11, 5'd1, 5'd2, 1'b0, 4'b0000, 3'b000, 32'h300 + 32'(i * 4));
            cycle(bubble_exp());
        end
        ex_redirect = 1'b0;
        check_counts("sat_flush", 3, 3);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
